hist_accum: RTL

HIST_ACCUM -- requirements
Module: hist_accum

---
 rtl/hist_accum.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hist_accum.sv
// hist_accum: windowed histogram accumulator with a post-window maximum search.
//
// Accepted samples are binned by their top BOUND_NUM_WIDTH bits. Each bin
// counter saturates. Every WIN_LEN accepted samples, the completed histogram
// (including the closing sample) is copied to a snapshot and the live bins
// restart from zero. A sequential search then finds the largest snapshot bin;
// ties go to the lowest index. A window that closes while the previous
// search is still running is dropped, and overrun_o flags it.
//
// Ports:
//   clk          - single clock, all logic on posedge
//   reset_n      - synchronous active-low reset
//   sample_i     - unsigned sample, BOUND_WIDTH bits
//   sample_val_i - sample_i accepted on every edge where high (no back-pressure)
//   data_o       - snapshot histogram, bin k at [k*DATA_WIDTH +: DATA_WIDTH]
//   max_num_o    - index of the largest snapshot bin
//   val_o        - one-cycle pulse, data_o/max_num_o valid
//   overrun_o    - one-cycle pulse, a completed window was discarded
module hist_accum #(
  parameter int DATA_WIDTH      = 16,
  parameter int BOUND_WIDTH     = 10,
  parameter int BOUND_NUM       = 32,
  parameter int BOUND_NUM_WIDTH = 5,
  parameter int WIN_LEN         = 1024
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [BOUND_WIDTH-1:0]          sample_i,
  input  logic                            sample_val_i,
  output logic [DATA_WIDTH*BOUND_NUM-1:0] data_o,
  output logic [BOUND_NUM_WIDTH-1:0]      max_num_o,
  output logic                            val_o,
  output logic                            overrun_o
);

  localparam int CNT_W = $clog2(WIN_LEN) + 1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                     state, state_next;
  logic [DATA_WIDTH-1:0]      live     [BOUND_NUM];
  logic [DATA_WIDTH-1:0]      live_inc [BOUND_NUM];
  logic [DATA_WIDTH-1:0]      snap     [BOUND_NUM];
  logic [CNT_W-1:0]           win_cnt;
  logic [BOUND_NUM_WIDTH-1:0] bin;
  logic [BOUND_NUM_WIDTH-1:0] search_idx;
  logic [BOUND_NUM_WIDTH-1:0] best_idx;
  logic [DATA_WIDTH-1:0]      best_val;
  logic                       closing;
  logic                       search_last;
  logic                       unused_sample;

  // Only the top bits select the bin; the remainder is intentionally ignored.
  assign unused_sample = ^sample_i;

  assign bin         = sample_i[BOUND_WIDTH-1 -: BOUND_NUM_WIDTH];
  assign closing     = sample_val_i && (win_cnt == CNT_W'(WIN_LEN - 1));
  assign search_last = (search_idx == BOUND_NUM_WIDTH'(BOUND_NUM - 1));

  // Live bins as they would be after this edge's sample; the snapshot takes
  // this view so the closing sample is counted in its own window.
  always_comb begin
    live_inc = live;
    if (sample_val_i && (live[bin] != '1)) begin
      live_inc[bin] = live[bin] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_cnt <= '0;
      for (int unsigned k = 0; k < BOUND_NUM; k++) live[k] <= '0;
    end else if (sample_val_i) begin
      if (closing) begin
        win_cnt <= '0;
        for (int unsigned k = 0; k < BOUND_NUM; k++) live[k] <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        live    <= live_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (closing) state_next = SEARCH;
      SEARCH:  if (search_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < BOUND_NUM; k++) snap[k] <= '0;
      search_idx <= '0;
      best_idx   <= '0;
      best_val   <= '0;
      max_num_o  <= '0;
      val_o      <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      val_o     <= 1'b0;
      overrun_o <= closing && (state != IDLE);
      case (state)
        IDLE: begin
          if (closing) begin
            snap       <= live_inc;
            search_idx <= '0;
            best_idx   <= '0;
            best_val   <= '0;
          end
        end
        SEARCH: begin
          // Strictly greater keeps the earliest index on ties.
          if (snap[search_idx] > best_val) begin
            best_val <= snap[search_idx];
            best_idx <= search_idx;
          end
          search_idx <= search_idx + 1'b1;
        end
        DONE: begin
          max_num_o <= best_idx;
          val_o     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < BOUND_NUM; k++) begin
      data_o[k*DATA_WIDTH +: DATA_WIDTH] = snap[k];
    end
  end

endmodule
